// File: rtl/sched_pkg.sv
// Shared types and defaults for the strict-priority packet scheduler.
package sched_pkg;

    localparam int DATA_W_DEF       = 256;
    localparam int NUM_PRI_DEF      = 8;
    localparam int STARVE_LIMIT_DEF = 16;
    localparam int PRI_W_DEF        = $clog2(NUM_PRI_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Counter width able to hold 0..limit; a limit of 0 still needs one bit.
    function automatic int starve_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    localparam int STARVE_W_DEF = starve_w(STARVE_LIMIT_DEF);

endpackage

// File: rtl/prio_pick.sv
// Combinational grant picker: starved candidates first, then the highest index.
module prio_pick
    import sched_pkg::*;
#(
    parameter int NUM_PRI = NUM_PRI_DEF,
    parameter int PRI_W   = $clog2(NUM_PRI)
) (
    input  logic [NUM_PRI-1:0] cand_i,
    input  logic [NUM_PRI-1:0] starved_i,
    output logic               gnt_vld_o,
    output logic [PRI_W-1:0]   gnt_idx_o
);

    logic [NUM_PRI-1:0] pool;

    // Narrow the pool to starved candidates when any exist; highest index in the pool wins.
    always_comb begin
        pool      = ((cand_i & starved_i) != '0) ? (cand_i & starved_i) : cand_i;
        gnt_vld_o = |cand_i;
        gnt_idx_o = '0;
        for (int i = 0; i < NUM_PRI; i++) begin
            if (pool[i]) begin
                gnt_idx_o = i[PRI_W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_pkt_sched.sv
// Strict-priority packet scheduler with anti-starvation promotion.
// One whole packet is drained from the granted FWFT queue before re-arbitrating.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate among queues holding a complete packet; grant
//   XFER  | pop words of cur_pri until eop, stalling on q_vld/out_rdy
module prio_pkt_sched
    import sched_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int NUM_PRI      = NUM_PRI_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int PRI_W        = $clog2(NUM_PRI)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PRI-1:0]        q_pkt,
    input  logic [NUM_PRI-1:0]        q_vld,
    input  logic [NUM_PRI-1:0]        q_sop,
    input  logic [NUM_PRI-1:0]        q_eop,
    input  logic [NUM_PRI*DATA_W-1:0] q_data,
    output logic [NUM_PRI-1:0]        q_read,
    input  logic                      out_rdy,
    output logic                      out_vld,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [DATA_W-1:0]         out_data,
    output logic [PRI_W-1:0]          cur_pri,
    output logic                      busy,
    output logic                      err
);

    localparam int                  STARVE_W = starve_w(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] LIMIT    = STARVE_W'(STARVE_LIMIT);

    state_e              state_q, state_d;
    logic [PRI_W-1:0]    cur_pri_q, cur_pri_d;
    logic                first_q, first_d;
    logic                err_q, err_d;
    logic                out_vld_q, out_vld_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [STARVE_W-1:0] cnt_q [NUM_PRI];
    logic [STARVE_W-1:0] cnt_d [NUM_PRI];

    logic [NUM_PRI-1:0]  starved;
    logic                gnt_vld;
    logic [PRI_W-1:0]    gnt_idx;
    logic                grant;
    logic                pop;
    logic                head_vld;
    logic                head_sop;
    logic                head_eop;
    logic [DATA_W-1:0]   head_data;

    // A queue is starved once its counter has saturated; a zero limit disables promotion.
    always_comb begin
        for (int i = 0; i < NUM_PRI; i++) begin
            starved[i] = (STARVE_LIMIT != 0) && (cnt_q[i] >= LIMIT);
        end
    end

    prio_pick #(
        .NUM_PRI (NUM_PRI),
        .PRI_W   (PRI_W)
    ) u_pick (
        .cand_i    (q_pkt),
        .starved_i (starved),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Head word of the granted queue.
    always_comb begin
        head_vld  = q_vld[cur_pri_q];
        head_sop  = q_sop[cur_pri_q];
        head_eop  = q_eop[cur_pri_q];
        head_data = q_data[int'(cur_pri_q) * DATA_W +: DATA_W];
    end

    // Pop only when the output register is empty or being drained this cycle.
    always_comb begin
        pop = (state_q == XFER) && head_vld && (!out_vld_q || out_rdy);
    end

    // Next-state, grant and pop strobe.
    always_comb begin
        state_d   = state_q;
        cur_pri_d = cur_pri_q;
        first_d   = first_q;
        grant     = 1'b0;
        q_read    = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant     = 1'b1;
                    cur_pri_d = gnt_idx;
                    first_d   = 1'b1;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (pop) begin
                    q_read[cur_pri_q] = 1'b1;
                    first_d           = 1'b0;
                    if (head_eop) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register load/hold/drain and sticky framing error.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_sop_d  = out_sop_q;
        out_eop_d  = out_eop_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        if (pop) begin
            out_vld_d  = 1'b1;
            // A missing sop on the first word is repaired so downstream still sees framing.
            out_sop_d  = head_sop | first_q;
            out_eop_d  = head_eop;
            out_data_d = head_data;
            if (first_q ? !head_sop : head_sop) begin
                err_d = 1'b1;
            end
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // Starvation counters move only on a grant: losers count up, everyone else clears.
    always_comb begin
        for (int i = 0; i < NUM_PRI; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant) begin
                if (q_pkt[i] && (int'(gnt_idx) != i)) begin
                    cnt_d[i] = (cnt_q[i] >= LIMIT) ? LIMIT : cnt_q[i] + 1'b1;
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_pri_q  <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_data_q <= '0;
            for (int i = 0; i < NUM_PRI; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_pri_q  <= cur_pri_d;
            first_q    <= first_d;
            err_q      <= err_d;
            out_vld_q  <= out_vld_d;
            out_sop_q  <= out_sop_d;
            out_eop_q  <= out_eop_d;
            out_data_q <= out_data_d;
            for (int i = 0; i < NUM_PRI; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_vld  = out_vld_q;
    assign out_sop  = out_sop_q;
    assign out_eop  = out_eop_q;
    assign out_data = out_data_q;
    assign cur_pri  = cur_pri_q;
    assign busy     = (state_q == XFER);
    assign err      = err_q;

endmodule

// File: tb/tb_prio_pkt_sched.sv
// Scoreboard bench for prio_pkt_sched: queue models feed the DUT, each pop pushes
// the expected output word, each output handshake pops and compares it.
module tb_prio_pkt_sched;

    localparam int DW = 32;
    localparam int NP = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   q_pkt, q_vld, q_sop, q_eop, q_read;
    logic [NP*DW-1:0] q_data;
    logic            out_rdy, out_vld, out_sop, out_eop;
    logic [DW-1:0]   out_data;
    logic [2:0]      cur_pri;
    logic            busy, err;

    prio_pkt_sched #(
        .DATA_W       (DW),
        .NUM_PRI      (NP),
        .STARVE_LIMIT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_pkt    (q_pkt),
        .q_vld    (q_vld),
        .q_sop    (q_sop),
        .q_eop    (q_eop),
        .q_data   (q_data),
        .q_read   (q_read),
        .out_rdy  (out_rdy),
        .out_vld  (out_vld),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_data (out_data),
        .cur_pri  (cur_pri),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    word_t mem [NP][64];
    int    rd_p [NP];
    int    wr_p [NP];
    word_t exp_q [$];
    int    exp_gnt [$];
    bit    in_pkt;
    int    pkt_q, pkt_words;
    int    stall_cnt;
    int    test_id;
    int    cyc, first_pop_cyc, last_pop_cyc;
    int    seq;
    bit    prev_stall;
    word_t prev_out;
    int    n_chk, n_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int q, input logic s, input logic e);
        word_t w;
        w.data = {8'(q), 24'(seq)};
        w.sop  = s;
        w.eop  = e;
        seq++;
        mem[q][wr_p[q]] = w;
        wr_p[q]++;
    endtask

    task automatic push_pkt(input int q, input int n);
        for (int k = 0; k < n; k++) push_word(q, k == 0, k == n - 1);
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NP; i++) begin
            logic has;
            logic pk;
            has = (rd_p[i] != wr_p[i]);
            pk  = 1'b0;
            for (int k = rd_p[i]; k < wr_p[i]; k++) if (mem[i][k].eop) pk = 1'b1;
            q_pkt[i]          = pk;
            q_vld[i]          = has;
            q_sop[i]          = has ? mem[i][rd_p[i]].sop : 1'b0;
            q_eop[i]          = has ? mem[i][rd_p[i]].eop : 1'b0;
            q_data[i*DW +: DW] = has ? mem[i][rd_p[i]].data : '0;
        end
        out_rdy = (stall_cnt == 0);
    endtask

    // One clock: drive at posedge+1, sample at posedge-1, update the model after the edge.
    task automatic cyc_step();
        logic [NP-1:0] s_read;
        logic          s_vld, s_rdy;
        logic [2:0]    s_cur;
        word_t         s_out, w, ex;
        drive_heads();
        #8;
        s_read     = q_read;
        s_vld      = out_vld;
        s_rdy      = out_rdy;
        s_cur      = cur_pri;
        s_out.data = out_data;
        s_out.sop  = out_sop;
        s_out.eop  = out_eop;
        if (prev_stall) begin
            check_val("hold_vld", s_vld, 1'b1);
            check_val("hold_word", s_out, prev_out);
        end
        if (s_vld && !s_rdy) check_val("stall_noread", s_read, '0);
        if (s_read != '0) check_val("read_onehot", $countones(s_read), 1);
        if (stall_cnt > 0) stall_cnt--;
        @(posedge clk);
        #1;
        cyc++;
        if (s_vld && s_rdy) begin
            if (exp_q.size() == 0) begin
                check_val("out_unexpected", s_out, '0);
            end else begin
                ex = exp_q.pop_front();
                check_val("out_word", s_out, ex);
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (s_read[i]) begin
                if (rd_p[i] == wr_p[i]) begin
                    check_val("pop_empty", i, 99);
                end else begin
                    w = mem[i][rd_p[i]];
                    rd_p[i]++;
                    ex = w;
                    if (!in_pkt) begin
                        if (exp_gnt.size() == 0) check_val("grant_extra", i, 99);
                        else check_val("grant", i, exp_gnt.pop_front());
                        check_val("cur_pri", s_cur, i);
                        in_pkt    = 1'b1;
                        pkt_q     = i;
                        pkt_words = 0;
                        ex.sop    = 1'b1;
                        if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    end else begin
                        check_val("no_interleave", i, pkt_q);
                        if (test_id == 3 && i == 1) check_val("t3_contig", cyc - last_pop_cyc, 1);
                    end
                    pkt_words++;
                    exp_q.push_back(ex);
                    last_pop_cyc = cyc;
                    if (w.eop) in_pkt = 1'b0;
                    if (test_id == 3 && i == 1 && pkt_words == 2) push_pkt(7, 2);
                    if (test_id == 4 && i == 0 && pkt_words == 1) stall_cnt = 3;
                end
            end
        end
        prev_stall = s_vld && !s_rdy;
        prev_out   = s_out;
    endtask

    function automatic bit model_done();
        bit d;
        d = (exp_q.size() == 0) && (exp_gnt.size() == 0) && !in_pkt;
        for (int i = 0; i < NP; i++) if (rd_p[i] != wr_p[i]) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (!model_done() && n < budget) begin
            cyc_step();
            n++;
        end
        if (n >= budget) check_val("timeout", n, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
        exp_q.delete();
        exp_gnt.delete();
        in_pkt        = 1'b0;
        stall_cnt     = 0;
        prev_stall    = 1'b0;
        first_pop_cyc = -1;
        last_pop_cyc  = 0;
    endtask

    task automatic do_reset();
        clear_model();
        rst = 1'b0;
        drive_heads();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_vld", out_vld, 1'b0);
        check_val("rst_out_sop", out_sop, 1'b0);
        check_val("rst_out_eop", out_eop, 1'b0);
        check_val("rst_out_data", out_data, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_err", err, 1'b0);
        check_val("rst_cur_pri", cur_pri, '0);
        check_val("rst_q_read", q_read, '0);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        seq   = 1;
        rst   = 1'b0;
        clear_model();
        drive_heads();

        // Reset mid-packet on q3, then re-grant from its current head.
        test_id = 1;
        do_reset();
        push_pkt(3, 4);
        exp_gnt.push_back(3);
        n = 0;
        while (!(in_pkt && pkt_words >= 2) && n < 20) begin
            cyc_step();
            n++;
        end
        if (n >= 20) check_val("t1_timeout", n, 0);
        #2;
        rst = 1'b0;
        #1;
        check_val("t1_async_out_vld", out_vld, 1'b0);
        check_val("t1_async_busy", busy, 1'b0);
        check_val("t1_async_q_read", q_read, '0);
        exp_q.delete();
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_gnt.push_back(3);
        run_until_done(40);
        check_val("t1_err", err, 1'b1);

        // Strict priority: q5 then q2, six cycles first pop to last pop.
        test_id = 2;
        do_reset();
        push_pkt(5, 3);
        push_pkt(2, 2);
        exp_gnt.push_back(5);
        exp_gnt.push_back(2);
        run_until_done(40);
        check_val("t2_span", last_pop_cyc - first_pop_cyc, 5);
        check_val("t2_err", err, 1'b0);

        // No preemption: q7 arrives during q1's packet.
        test_id = 3;
        do_reset();
        push_pkt(1, 4);
        exp_gnt.push_back(1);
        exp_gnt.push_back(7);
        run_until_done(40);
        check_val("t3_err", err, 1'b0);

        // Backpressure on q0 after word 1.
        test_id = 4;
        do_reset();
        push_pkt(0, 4);
        exp_gnt.push_back(0);
        run_until_done(40);
        check_val("t4_err", err, 1'b0);

        // Starvation promotion with a limit of 2.
        test_id = 5;
        do_reset();
        for (int k = 0; k < 4; k++) push_pkt(7, 1);
        push_pkt(0, 2);
        exp_gnt.push_back(7);
        exp_gnt.push_back(7);
        exp_gnt.push_back(0);
        exp_gnt.push_back(7);
        exp_gnt.push_back(7);
        run_until_done(60);
        check_val("t5_err", err, 1'b0);

        // Missing sop on q4 first word: sop repaired, err sticky.
        test_id = 6;
        do_reset();
        push_word(4, 1'b0, 1'b1);
        exp_gnt.push_back(4);
        run_until_done(20);
        check_val("t6_err", err, 1'b1);
        push_pkt(4, 2);
        exp_gnt.push_back(4);
        run_until_done(20);
        check_val("t6_err_sticky", err, 1'b1);

        // Extra sop inside a q6 packet: forwarded unchanged, err set.
        test_id = 7;
        do_reset();
        push_word(6, 1'b1, 1'b0);
        push_word(6, 1'b1, 1'b0);
        push_word(6, 1'b0, 1'b1);
        exp_gnt.push_back(6);
        run_until_done(20);
        check_val("t7_err", err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
